button_debounce: RTL and testbench
==================================

BUTTON_DEBOUNCE -- requirements
Module: button_debounce

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 1000: number of consecutive synchronized samples, after the first, that must agree before a level change is accepted; legal range 2..65535.
REQ-002 SHALL have port i_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port i_reset_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port i_btn, input, 1 bit: raw mechanical button level, active-high, asynchronous to i_clk.
REQ-005 SHALL have port o_btn, output, 1 bit: debounced button level.
REQ-006 SHALL have port o_press, output, 1 bit: one-cycle pulse on each accepted 0->1 change.
REQ-007 SHALL have port o_release, output, 1 bit: one-cycle pulse on each accepted 1->0 change.
REQ-008 SHALL have port o_led, output, 1 bit: press-toggled LED level (see Configuration).

Function
REQ-009 SHALL pass i_btn through a 2-flop synchronizer; the second flop's output is "sync".
REQ-010 SHALL implement four states: IDLE_LO, WAIT_HI, IDLE_HI, WAIT_LO.
REQ-011 In IDLE_LO, sync=1 SHALL move to WAIT_HI and clear the counter; sync=0 SHALL hold.
REQ-012 In WAIT_HI, sync=0 SHALL return to IDLE_LO with no output change (glitch rejected).
REQ-013 In WAIT_HI with sync=1 and counter below STABLE_CYCLES-1, the counter SHALL increment.
REQ-014 In WAIT_HI with sync=1 and counter = STABLE_CYCLES-1, the block SHALL move to IDLE_HI, set o_btn=1 and pulse o_press for exactly one cycle.
REQ-015 IDLE_HI, WAIT_LO, o_release and the transition back to IDLE_LO with o_btn=0 SHALL mirror REQ-011..014 with opposite polarity.
REQ-016 An i_btn change SHALL be accepted if held for STABLE_CYCLES+1 consecutive sampling edges; if held for STABLE_CYCLES or fewer, it SHALL be rejected.
REQ-017 Latency: o_btn SHALL change on the (STABLE_CYCLES+3)th rising edge, counting the first edge that samples the new i_btn level as edge 1.
REQ-018 The counter SHALL be $clog2(STABLE_CYCLES) bits wide, SHALL never wrap, and its value SHALL be ignored outside the WAIT states.
REQ-019 o_press and o_release SHALL never be asserted in the same cycle.
REQ-020 All outputs SHALL be registered.

Reset
REQ-021 While i_reset_n=0, the block SHALL immediately set: synchronizer flops=0, state=IDLE_LO, counter=0, o_btn=0, o_press=0, o_release=0, o_led=0.
REQ-022 An assertion of i_reset_n mid-debounce SHALL abandon the pending change with no pulse.
REQ-023 If i_btn is held high across reset release, the block SHALL debounce normally and emit o_press per REQ-017.

Configuration
REQ-024 With macro BUTTON_DEBOUNCE_TOGGLE_EN defined, o_led SHALL toggle on the same edge o_press asserts.
REQ-025 Without BUTTON_DEBOUNCE_TOGGLE_EN, o_led SHALL be constant 0 and no toggle register SHALL exist.

Verification (STABLE_CYCLES=4)
REQ-026 i_btn high for 4 edges then low -> o_btn, o_press and o_release stay 0 throughout.
REQ-027 i_btn high from edge 1 and held -> o_btn=1 and o_press=1 after edge 7; o_press=0 after edge 8.
REQ-028 From debounced high, i_btn low and held -> o_release pulses one cycle with o_btn falling after the 7th edge; o_press stays 0.
REQ-029 Bounce high/low alternating each edge for 20 edges, then held high -> exactly one o_press, 7 edges after the final rise.
REQ-030 i_reset_n pulsed low during WAIT_HI at counter=2 -> all outputs 0 immediately and no pulse; if i_btn is still high, one o_press follows 7 edges after reset release.
REQ-031 With BUTTON_DEBOUNCE_TOGGLE_EN, three accepted presses -> o_led reads 1,0,1; without the macro -> o_led stays 0.

Source files
------------

// File: rtl/button_debounce.sv
// button_debounce: 2-flop synchronizer feeding a four-state debounce FSM with press/release pulses.
// Optional press-toggled LED output is built only when BUTTON_DEBOUNCE_TOGGLE_EN is defined.
module button_debounce #(
  parameter int unsigned STABLE_CYCLES = 32'd1000
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_btn,
  output logic o_btn,
  output logic o_press,
  output logic o_release,
  output logic o_led
);

  localparam int unsigned      CNT_W    = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(32'd0);

  localparam logic [1:0] IDLE_LO = 2'd0;
  localparam logic [1:0] WAIT_HI = 2'd1;
  localparam logic [1:0] IDLE_HI = 2'd2;
  localparam logic [1:0] WAIT_LO = 2'd3;

  logic             sync_meta_r;
  logic             sync_r;
  logic [1:0]       state_r;
  logic [1:0]       state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic             btn_r;
  logic             btn_nxt_s;
  logic             press_r;
  logic             press_nxt_s;
  logic             release_r;
  logic             release_nxt_s;

  // Two-flop synchronizer for the asynchronous button input.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sync_meta_r <= 1'b0;
      sync_r      <= 1'b0;
    end else begin
      sync_meta_r <= i_btn;
      sync_r      <= sync_meta_r;
    end
  end

  // Next-state logic: a level change is accepted only after the counter reaches its last value.
  always_comb begin
    state_nxt_s   = state_r;
    cnt_nxt_s     = cnt_r;
    btn_nxt_s     = btn_r;
    press_nxt_s   = 1'b0;
    release_nxt_s = 1'b0;
    case (state_r)
      IDLE_LO: begin
        if (sync_r) begin
          state_nxt_s = WAIT_HI;
          cnt_nxt_s   = CNT_ZERO;
        end else begin
          state_nxt_s = IDLE_LO;
        end
      end
      WAIT_HI: begin
        if (!sync_r) begin
          state_nxt_s = IDLE_LO;
        end else if (cnt_r == CNT_LAST) begin
          state_nxt_s = IDLE_HI;
          btn_nxt_s   = 1'b1;
          press_nxt_s = 1'b1;
        end else begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
      end
      IDLE_HI: begin
        if (!sync_r) begin
          state_nxt_s = WAIT_LO;
          cnt_nxt_s   = CNT_ZERO;
        end else begin
          state_nxt_s = IDLE_HI;
        end
      end
      WAIT_LO: begin
        if (sync_r) begin
          state_nxt_s = IDLE_HI;
        end else if (cnt_r == CNT_LAST) begin
          state_nxt_s   = IDLE_LO;
          btn_nxt_s     = 1'b0;
          release_nxt_s = 1'b1;
        end else begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_nxt_s = IDLE_LO;
        cnt_nxt_s   = CNT_ZERO;
        btn_nxt_s   = 1'b0;
      end
    endcase
  end

  // FSM state, counter and registered outputs.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_r   <= IDLE_LO;
      cnt_r     <= CNT_ZERO;
      btn_r     <= 1'b0;
      press_r   <= 1'b0;
      release_r <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      cnt_r     <= cnt_nxt_s;
      btn_r     <= btn_nxt_s;
      press_r   <= press_nxt_s;
      release_r <= release_nxt_s;
    end
  end

  assign o_btn     = btn_r;
  assign o_press   = press_r;
  assign o_release = release_r;

`ifdef BUTTON_DEBOUNCE_TOGGLE_EN
  logic led_r;

  // LED flips on the same edge that raises o_press.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      led_r <= 1'b0;
    end else if (press_nxt_s) begin
      led_r <= ~led_r;
    end else begin
      led_r <= led_r;
    end
  end

  assign o_led = led_r;
`else
  assign o_led = 1'b0;
`endif

endmodule

// File: tb/tb_button_debounce.sv
// Self-checking bench for button_debounce: run-length reference model compared every cycle,
// plus directed edge-exact scenarios and randomized bouncing input.
module tb_button_debounce;

  localparam int S = 4;

  logic i_clk     = 1'b0;
  logic i_reset_n = 1'b0;
  logic i_btn     = 1'b0;
  logic o_btn, o_press, o_release, o_led;

  int checks = 0;
  int errors = 0;

  button_debounce #(.STABLE_CYCLES(S)) dut (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_btn     (i_btn),
    .o_btn     (o_btn),
    .o_press   (o_press),
    .o_release (o_release),
    .o_led     (o_led)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Reference model: a level is accepted once S+1 consecutive samples differ from the
  // accepted level; the two-flop synchronizer delays the visible effect by two edges.
  logic       m_deb;
  int         m_run;
  logic       m_led;
  logic [3:0] st0, st1, ex;   // {btn, press, release, led}

  always @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      m_deb <= 1'b0;
      m_run <= 0;
      m_led <= 1'b0;
      st0   <= 4'b0000;
      st1   <= 4'b0000;
      ex    <= 4'b0000;
    end else begin
      if (i_btn != m_deb) begin
        if (m_run + 1 == S + 1) begin
          m_deb <= i_btn;
          m_run <= 0;
          m_led <= m_led ^ i_btn;
          st0   <= {i_btn, i_btn, ~i_btn, m_led ^ i_btn};
        end else begin
          m_run <= m_run + 1;
          st0   <= {m_deb, 1'b0, 1'b0, m_led};
        end
      end else begin
        m_run <= 0;
        st0   <= {m_deb, 1'b0, 1'b0, m_led};
      end
      st1 <= st0;
      ex  <= st1;
    end
  end

  // Compare DUT against the model on every falling edge.
  always @(negedge i_clk) begin
    chk("model_btn", o_btn, ex[3]);
    chk("model_press", o_press, ex[2]);
    chk("model_release", o_release, ex[1]);
`ifdef BUTTON_DEBOUNCE_TOGGLE_EN
    chk("model_led", o_led, ex[0]);
`else
    chk("model_led", o_led, 1'b0);
`endif
    chk("press_release_exclusive", o_press & o_release, 1'b0);
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    int npress;
    int press_at;
    logic exp_led;

    // Reset state
    i_reset_n = 1'b0;
    i_btn     = 1'b0;
    repeat (3) step();
    chk("reset_btn", o_btn, 1'b0);
    chk("reset_press", o_press, 1'b0);
    chk("reset_release", o_release, 1'b0);
    chk("reset_led", o_led, 1'b0);
    #2 i_reset_n = 1'b1;
    repeat (3) step();

    // Held for only S edges: rejected
    i_btn = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      step();
      chk("reject_hold", o_btn | o_press | o_release, 1'b0);
    end
    i_btn = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      step();
      chk("reject_after", o_btn | o_press | o_release, 1'b0);
    end

    // Accepted press: o_btn and o_press after edge 7
    i_btn = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      step();
      if (e < 7) begin
        chk("press_early", o_btn | o_press, 1'b0);
      end else if (e == 7) begin
        chk("press_btn_e7", o_btn, 1'b1);
        chk("press_pulse_e7", o_press, 1'b1);
      end else begin
        chk("press_pulse_e8", o_press, 1'b0);
        chk("press_btn_e8", o_btn, 1'b1);
      end
    end
    repeat (2) step();

    // Accepted release
    i_btn = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      step();
      if (e < 7) begin
        chk("release_early_btn", o_btn, 1'b1);
        chk("release_early_pulse", o_release, 1'b0);
      end else if (e == 7) begin
        chk("release_btn_e7", o_btn, 1'b0);
        chk("release_pulse_e7", o_release, 1'b1);
        chk("release_no_press", o_press, 1'b0);
      end else begin
        chk("release_pulse_e8", o_release, 1'b0);
      end
    end

    // Bounce 20 edges then held high: exactly one press, 7 edges after final rise
    npress   = 0;
    press_at = 0;
    for (int e = 0; e < 20; e++) begin
      i_btn = (e % 2 == 0);
      step();
      if (o_press) npress++;
    end
    i_btn = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (o_press) begin
        npress++;
        press_at = k;
      end
    end
    chk_int("bounce_press_count", npress, 1);
    chk_int("bounce_press_edge", press_at, 7);
    chk("bounce_btn", o_btn, 1'b1);

    // Reset during WAIT_HI at counter=2
    i_btn = 1'b0;
    repeat (10) step();
    i_btn = 1'b1;
    repeat (5) step();
    i_reset_n = 1'b0;
    #1;
    chk("midreset_btn", o_btn, 1'b0);
    chk("midreset_press", o_press, 1'b0);
    chk("midreset_release", o_release, 1'b0);
    chk("midreset_led", o_led, 1'b0);
    repeat (2) begin
      step();
      chk("inreset_outputs", o_btn | o_press | o_release | o_led, 1'b0);
    end
    #2 i_reset_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (k < 7) begin
        chk("postreset_early", o_press | o_btn, 1'b0);
      end else if (k == 7) begin
        chk("postreset_press", o_press, 1'b1);
        chk("postreset_btn", o_btn, 1'b1);
      end else begin
        chk("postreset_press_end", o_press, 1'b0);
      end
    end

    // Three accepted presses: LED sequence
    i_reset_n = 1'b0;
    i_btn     = 1'b0;
    step();
    #2 i_reset_n = 1'b1;
    for (int p = 0; p < 3; p++) begin
      i_btn = 1'b1;
      repeat (8) step();
`ifdef BUTTON_DEBOUNCE_TOGGLE_EN
      exp_led = (p % 2 == 0);
`else
      exp_led = 1'b0;
`endif
      chk("led_after_press", o_led, exp_led);
      i_btn = 1'b0;
      repeat (8) step();
      chk("led_after_release", o_led, exp_led);
    end

    // Randomized bouncing with occasional asynchronous resets
    for (int r = 0; r < 400; r++) begin
      i_btn = 1'($urandom_range(0, 1));
      repeat ($urandom_range(1, 2 * S + 1)) step();
      if ($urandom_range(0, 49) == 0) begin
        i_reset_n = 1'b0;
        #2 i_reset_n = 1'b1;
      end
    end
    i_btn = 1'b0;
    repeat (20) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
